// File: rtl/haar_pkg.sv
// Shared definitions for the stage loader: FSM states and the ROM word layout.
package haar_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR_REQ,
        HDR_WAIT,
        DATA,
        DONE
    } state_t;

    // Each stage is one header word followed by its entry words.
    localparam int HDR_WORDS     = 1;
    localparam int ENTRY_WORDS   = 1;
    // The entry count occupies the low bits of the header word.
    localparam int HDR_COUNT_LSB = 0;

endpackage

// File: rtl/stage_load_controller_if.sv
// ROM read port and entry stream of the stage loader, grouped as one bundle.
interface stage_load_controller_if #(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 16,
    parameter int STAGE_WIDTH = 5
);
    logic                   o_ren;
    logic [ADDR_WIDTH-1:0]  o_address;
    logic [DATA_WIDTH-1:0]  i_rom_data;
    logic                   o_valid;
    logic [DATA_WIDTH-1:0]  o_data;
    logic [STAGE_WIDTH-1:0] o_stage;
    logic                   o_last;
    logic                   i_ready;

    modport master (
        output o_ren, o_address, o_valid, o_data, o_stage, o_last,
        input  i_rom_data, i_ready
    );

    modport slave (
        input  o_ren, o_address, o_valid, o_data, o_stage, o_last,
        output i_rom_data, i_ready
    );
endinterface

// File: rtl/stage_fifo2.sv
// Two-entry FIFO carrying {last, stage, data}; flush empties it in one cycle.
module stage_fifo2 #(
    parameter int W = 22
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [1:0]   count_o
);
    logic [W-1:0] mem_q [2];
    logic         wr_q, wr_d, rd_q, rd_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         do_push, do_pop;

    always_comb begin
        do_pop  = pop_i && (cnt_q != 2'd0);
        do_push = push_i && ((cnt_q != 2'd2) || do_pop);
        wr_d    = wr_q ^ do_push;
        rd_d    = rd_q ^ do_pop;
        cnt_d   = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 2'd1;
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_q] <= din_i;
        end
    end

    assign dout_o  = mem_q[rd_q];
    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);
    assign count_o = cnt_q;
endmodule

// File: rtl/stage_load_controller.sv
// Walks a header-prefixed stage table in an external ROM and streams each
// stage's entries, tagged with stage index and last flag, through a 2-deep FIFO.
module stage_load_controller
    import haar_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 16,
    parameter int STAGE_WIDTH = 5
) (
    input  logic                   clk_fpga,
    input  logic                   reset_fpga,
    input  logic                   i_start,
    input  logic [STAGE_WIDTH-1:0] i_num_stages,
    input  logic                   i_abort,
    stage_load_controller_if.master bus,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_error
);
    localparam int PW = 1 + STAGE_WIDTH + DATA_WIDTH;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH:0]    addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]  remain_q, remain_d;
    logic [STAGE_WIDTH-1:0] stage_q, stage_d, nstages_q, nstages_d;
    logic                   error_q, error_d;
    logic                   infl_q, infl_d, infl_last_q, infl_last_d;
    logic [STAGE_WIDTH-1:0] infl_stage_q, infl_stage_d;

    logic                   ren, done, flush, pop, can_read, final_stage;
    logic                   fifo_full, fifo_empty;
    logic [1:0]             fifo_count;
    logic [2:0]             occ;
    logic [PW-1:0]          fifo_dout, out_word;
    logic [ADDR_WIDTH-1:0]  hdr_count;

    assign pop         = !fifo_empty && bus.i_ready;
    // Credit the entry leaving this cycle so a steady stream sustains one read per cycle.
    assign occ         = {1'b0, fifo_count} + {2'b00, infl_q} - {2'b00, pop};
    assign can_read    = !fifo_full && (occ < 3'd2);
    assign final_stage = (stage_q + STAGE_WIDTH'(1)) == nstages_q;
    assign hdr_count   = bus.i_rom_data[HDR_COUNT_LSB +: ADDR_WIDTH];

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        remain_d     = remain_q;
        stage_d      = stage_q;
        nstages_d    = nstages_q;
        error_d      = error_q;
        infl_d       = 1'b0;
        infl_last_d  = 1'b0;
        infl_stage_d = stage_q;
        ren          = 1'b0;
        done         = 1'b0;
        flush        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    addr_d    = '0;
                    stage_d   = '0;
                    nstages_d = i_num_stages;
                    error_d   = 1'b0;
                    state_d   = (i_num_stages == '0) ? DONE : HDR_REQ;
                end
            end
            HDR_REQ: begin
                // The top address bit flags a read that would wrap past the ROM end.
                if (addr_q[ADDR_WIDTH]) begin
                    error_d = 1'b1;
                    state_d = DONE;
                end else begin
                    ren     = 1'b1;
                    addr_d  = addr_q + (ADDR_WIDTH+1)'(HDR_WORDS);
                    state_d = HDR_WAIT;
                end
            end
            HDR_WAIT: begin
                remain_d = hdr_count;
                if (hdr_count != '0) begin
                    state_d = DATA;
                end else if (final_stage) begin
                    state_d = DONE;
                end else begin
                    stage_d = stage_q + STAGE_WIDTH'(1);
                    state_d = HDR_REQ;
                end
            end
            DATA: begin
                if (addr_q[ADDR_WIDTH]) begin
                    error_d = 1'b1;
                    state_d = DONE;
                end else if (can_read) begin
                    ren         = 1'b1;
                    addr_d      = addr_q + (ADDR_WIDTH+1)'(ENTRY_WORDS);
                    remain_d    = remain_q - ADDR_WIDTH'(1);
                    infl_d      = 1'b1;
                    infl_last_d = (remain_q == ADDR_WIDTH'(1));
                    if (remain_q == ADDR_WIDTH'(1)) begin
                        if (final_stage) begin
                            state_d = DONE;
                        end else begin
                            stage_d = stage_q + STAGE_WIDTH'(1);
                            state_d = HDR_REQ;
                        end
                    end
                end
            end
            DONE: begin
                if (fifo_empty && !infl_q) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (i_abort && (state_q != IDLE)) begin
            state_d  = IDLE;
            addr_d   = addr_q;
            remain_d = remain_q;
            stage_d  = stage_q;
            error_d  = error_q;
            infl_d   = 1'b0;
            flush    = 1'b1;
            ren      = 1'b0;
            done     = 1'b0;
        end
    end

    always_ff @(posedge clk_fpga) begin
        if (reset_fpga) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            remain_q  <= '0;
            stage_q   <= '0;
            nstages_q <= '0;
            error_q   <= 1'b0;
            infl_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            remain_q  <= remain_d;
            stage_q   <= stage_d;
            nstages_q <= nstages_d;
            error_q   <= error_d;
            infl_q    <= infl_d;
        end
    end

    always_ff @(posedge clk_fpga) begin
        infl_last_q  <= infl_last_d;
        infl_stage_q <= infl_stage_d;
    end

    stage_fifo2 #(.W(PW)) u_fifo (
        .clk_i   (clk_fpga),
        .rst_i   (reset_fpga),
        .push_i  (infl_q),
        .pop_i   (pop),
        .flush_i (flush),
        .din_i   ({infl_last_q, infl_stage_q, bus.i_rom_data}),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign out_word      = fifo_empty ? '0 : fifo_dout;
    assign bus.o_ren     = ren;
    assign bus.o_address = addr_q[ADDR_WIDTH-1:0];
    assign bus.o_valid   = !fifo_empty;
    assign bus.o_last    = out_word[PW-1];
    assign bus.o_stage   = out_word[DATA_WIDTH +: STAGE_WIDTH];
    assign bus.o_data    = out_word[DATA_WIDTH-1:0];
    assign o_busy        = (state_q != IDLE);
    assign o_done        = done;
    assign o_error       = error_q;
endmodule
